// File: rtl/complex_fxp_mac.sv
// Fixed-point complex multiply / multiply-accumulate unit with a two-register pipeline.
// It uses a valid/ready handshake, passes the tag through, and reports saturation per lane.
module complex_fxp_mac #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int GUARD     = 8,
    parameter int TAG_WIDTH = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      flush_i,
    input  logic [3:0][WIDTH-1:0]     operands_i,
    input  logic [1:0]                op_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    output logic [1:0][WIDTH-1:0]     result_o,
    output logic [1:0]                status_o,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        OP_MUL     = 2'b00,
        OP_CMUL    = 2'b01,
        OP_MAC     = 2'b10,
        OP_MAC_CLR = 2'b11
    } op_e;

    localparam int PW    = 2 * WIDTH;
    localparam int SW    = PW + 1;
    localparam int ACC_W = SW + GUARD;

    localparam logic signed [ACC_W:0] ROUND_C = (ACC_W + 1)'(1) << (FRAC - 1);
    localparam logic signed [ACC_W:0] MAX_V   = {{(ACC_W - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V   = {{(ACC_W - WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic adv;
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv && !flush_i;

    // Operands are widened to product width first, so -(-2^(WIDTH-1)) for CMUL cannot overflow.
    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x, bi_eff;
    assign ar_x   = {{WIDTH{operands_i[0][WIDTH-1]}}, operands_i[0]};
    assign ai_x   = {{WIDTH{operands_i[1][WIDTH-1]}}, operands_i[1]};
    assign br_x   = {{WIDTH{operands_i[2][WIDTH-1]}}, operands_i[2]};
    assign bi_x   = {{WIDTH{operands_i[3][WIDTH-1]}}, operands_i[3]};
    assign bi_eff = (op_i == OP_CMUL) ? -bi_x : bi_x;

    logic                 s1_valid;
    op_e                  s1_op;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic signed [PW-1:0] s1_rr, s1_ii, s1_ri, s1_ir;

    logic signed [SW-1:0]    raw_re, raw_im;
    logic signed [ACC_W-1:0] acc_re, acc_im, raw_re_x, raw_im_x;
    logic signed [ACC_W-1:0] acc_next_re, acc_next_im, val_re, val_im;
    logic [WIDTH:0]          rs_re, rs_im;
    logic                    is_mac;

    assign raw_re   = SW'(s1_rr) - SW'(s1_ii);
    assign raw_im   = SW'(s1_ri) + SW'(s1_ir);
    assign raw_re_x = ACC_W'(raw_re);
    assign raw_im_x = ACC_W'(raw_im);
    assign is_mac   = (s1_op == OP_MAC) || (s1_op == OP_MAC_CLR);

    // Accumulator overflow wraps, so a plain ACC_W-bit add is intended.
    assign acc_next_re = (s1_op == OP_MAC) ? acc_re + raw_re_x : raw_re_x;
    assign acc_next_im = (s1_op == OP_MAC) ? acc_im + raw_im_x : raw_im_x;
    assign val_re      = is_mac ? acc_next_re : raw_re_x;
    assign val_im      = is_mac ? acc_next_im : raw_im_x;

    // Returns {clamped, value}: round half-up at FRAC, then clamp to WIDTH bits.
    function automatic logic [WIDTH:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] r;
        r = ((ACC_W + 1)'(v) + ROUND_C) >>> FRAC;
        if (r > MAX_V) return {1'b1, MAX_V[WIDTH-1:0]};
        if (r < MIN_V) return {1'b1, MIN_V[WIDTH-1:0]};
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    assign rs_re = round_sat(val_re);
    assign rs_im = round_sat(val_im);

    assign busy_o = s1_valid || out_valid_o;

    // NOTE: every register below uses <= so all stages sample the pre-edge values together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_MUL;
            s1_tag      <= '0;
            s1_rr       <= '0;
            s1_ii       <= '0;
            s1_ri       <= '0;
            s1_ir       <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            status_o    <= '0;
            tag_o       <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
        end else if (flush_i) begin
            s1_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            acc_re      <= '0;
            acc_im      <= '0;
        end else if (adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_op  <= op_e'(op_i);
                s1_tag <= tag_i;
                s1_rr  <= ar_x * br_x;
                s1_ii  <= ai_x * bi_eff;
                s1_ri  <= ar_x * bi_eff;
                s1_ir  <= ai_x * br_x;
            end
            out_valid_o <= s1_valid;
            // The accumulator moves only on a real S1->S2 transfer, so a stalled MAC is not repeated.
            if (s1_valid) begin
                result_o[0] <= rs_re[WIDTH-1:0];
                result_o[1] <= rs_im[WIDTH-1:0];
                status_o    <= {rs_im[WIDTH], rs_re[WIDTH]};
                tag_o       <= s1_tag;
                if (is_mac) begin
                    acc_re <= acc_next_re;
                    acc_im <= acc_next_im;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_fxp_mac.sv
// Scoreboard bench for complex_fxp_mac: directed vectors push expected results,
// and a negedge monitor pops and compares each result the DUT hands over.
module tb_complex_fxp_mac;

    localparam int WIDTH = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 flush_i;
    logic [3:0][WIDTH-1:0] operands_i;
    logic [1:0]           op_i;
    logic [0:0]           tag_i;
    logic [1:0][WIDTH-1:0] result_o;
    logic [1:0]           status_o;
    logic [0:0]           tag_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 busy_o;

    complex_fxp_mac #(.WIDTH(16), .FRAC(8), .GUARD(8), .TAG_WIDTH(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .flush_i(flush_i), .operands_i(operands_i), .op_i(op_i), .tag_i(tag_i),
        .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [1:0]  st;
        logic        tag;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed when valid and ready are both high and no flush drops it.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got re=%h im=%h with empty scoreboard", result_o[0], result_o[1]);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("txn%0d_re", e.id), 32'(result_o[0]), 32'(e.re));
                check($sformatf("txn%0d_im", e.id), 32'(result_o[1]), 32'(e.im));
                check($sformatf("txn%0d_status", e.id), 32'(status_o), 32'(e.st));
                check($sformatf("txn%0d_tag", e.id), 32'(tag_o), 32'(e.tag));
            end
        end
    end

    // Issues one operation and waits for acceptance; the expected result is queued only when push=1.
    task automatic send(input logic [1:0] op, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi, input logic tag,
                        input logic push, input logic [15:0] ere, input logic [15:0] eim,
                        input logic [1:0] est);
        int waited = 0;
        bit ok = 1'b1;
        in_valid_i    = 1'b1;
        op_i          = op;
        operands_i[0] = ar;
        operands_i[1] = ai;
        operands_i[2] = br;
        operands_i[3] = bi;
        tag_i         = tag;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready_o stayed %b, required 1", in_ready_o);
                ok = 1'b0;
                break;
            end
        end
        if (ok && push) begin
            exp_t e;
            e.re = ere; e.im = eim; e.st = est; e.tag = tag; e.id = next_id;
            sb.push_back(e);
        end
        next_id++;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [15:0] A_RE = 16'h0180, A_IM = 16'h0200, B_RE = 16'h0080, B_IM = 16'hFF00;

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        operands_i = '0; op_i = 2'b00; tag_i = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_status_tag", {29'd0, status_o, tag_o}, 32'd0);
        @(posedge clk_i);
        #1;

        // MUL with latency check: valid appears only after the second edge.
        send(2'b00, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
        check("lat_after_edge_n", 32'(out_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("lat_after_edge_n1", 32'(out_valid_o), 32'd1);
        drain();

        // CMUL, rounding, saturation on each lane and both signs, CMUL with b_im at the most negative value.
        send(2'b01, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b1, 16'hFEC0, 16'h0280, 2'b00);
        send(2'b00, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0000, 2'b00);
        send(2'b00, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00);
        send(2'b00, 16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 16'h0000, 2'b01);
        send(2'b00, 16'h8000, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b1, 16'h8000, 16'h0000, 2'b01);
        send(2'b00, 16'h0000, 16'h7F00, 16'h0200, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h7FFF, 2'b10);
        send(2'b01, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h0000, 16'h7FFF, 2'b10);
        drain();

        // MAC_CLR, MAC, then a MUL that must leave acc alone, then MAC again.
        send(2'b11, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b1, 16'h0580, 16'hFF00, 2'b00);
        send(2'b00, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b1, 16'h0840, 16'hFE80, 2'b00);
        drain();

        // Flush kills an in-flight MAC and clears acc.
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00);
        flush_i = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
        drain();

        // Back-pressure: 4 accumulating ops with out_ready_i low for 3 cycles mid-stream.
        fork
            begin
                send(2'b11, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
                send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h0580, 16'hFF00, 2'b00);
                send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b1, 16'h0840, 16'hFE80, 2'b00);
                send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h0B00, 16'hFE00, 2'b00);
            end
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_i);
                    check("bp_in_ready", 32'(in_ready_o), 32'd0);
                    check("bp_out_valid", 32'(out_valid_o), 32'd1);
                    check("bp_hold_re", 32'(result_o[0]), 32'h02C0);
                    check("bp_hold_im", 32'(result_o[1]), 32'hFF80);
                    check("bp_hold_tag", 32'(tag_o), 32'd0);
                end
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain();

        // Asynchronous reset while both stages hold data.
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        send(2'b10, A_RE, A_IM, B_RE, B_IM, 1'b1, 1'b1, 16'h02C0, 16'hFF80, 2'b00);
        drain();
        repeat (3) @(posedge clk_i);
        check("final_busy", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors so far", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/complex_fxp_mac.md
# complex_fxp_mac

Parametrised fixed-point complex multiply / multiply-accumulate unit with a valid/ready handshake, tag pass-through and per-lane saturation status. It sits in the same datapath slot as the floating-point complex divider: the host issues complex operand pairs and collects complex results. It adds conjugate multiply, accumulation and a configurable Q-format. The fixed two-register pipeline stalls globally under back-pressure.

## Interface
- WIDTH, 16, operand/result width per real or imaginary part, signed two's complement
- FRAC, 8, fractional bits of the Q format (1 ≤ FRAC < WIDTH)
- GUARD, 8, extra accumulator integer bits
- TAG_WIDTH, 1, width of the sideband tag
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  unit can accept operands
- flush_i  in  1  synchronous kill of in-flight work and accumulator
- operands_i  in  [3:0][WIDTH-1:0]  {b_im, b_re, a_im, a_re} (index 0 = a_re)
- op_i  in  2  00 MUL a·b, 01 CMUL a·conj(b), 10 MAC acc+=a·b, 11 MAC_CLR acc=a·b
- tag_i  in  TAG_WIDTH  sideband tag, returned with the result
- result_o  out  [1:0][WIDTH-1:0]  [0]=real, [1]=imag
- status_o  out  2  {sat_im, sat_re}: saturation occurred on that lane
- tag_o  out  TAG_WIDTH  tag of the presented result
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- busy_o  out  1  any pipeline stage holds valid data

## Operation
- Stage 1 (S1) registers the four products ar·br, ai·bi, ar·bi, ai·br (2·WIDTH bits each), plus op and tag. For CMUL, the sign of b_im is inverted before multiplication.
- Stage 2 (S2) forms the raw complex product:
  - re = ar·br − ai·bi
  - im = ar·bi + ai·br
  - The raw sum is 2·WIDTH+1 bits.
- Accumulator: ACC_W = 2·WIDTH+1+GUARD bits per lane, kept at full product precision.
  - MAC adds the raw sum to acc.
  - MAC_CLR loads acc with the raw sum.
  - MUL and CMUL leave acc unchanged.
  - Accumulator overflow wraps silently.
- Output value: the raw sum for MUL/CMUL, or the new acc for MAC/MAC_CLR. It is then rounded and saturated:
  - Round half-up: add 2^(FRAC−1), then arithmetic shift right by FRAC.
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - The status bit for a lane is set when that lane clamped.
- The accumulator updates only when the S1→S2 transfer actually occurs. A stalled MAC does not re-accumulate.
- Global advance: adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv && !flush_i.
  - All stages load only when adv = 1.
- flush_i = 1 has the following effect at the next edge:
  - S1 valid, S2 valid and out_valid_o clear.
  - acc clears.
  - in_valid_i is ignored that cycle.
- Reset values: out_valid_o=0, result_o=0, status_o=0, tag_o=0, busy_o=0, acc=0, all internal valids 0. in_ready_o=1 (combinational, after reset).

## Timing
- Latency 2: a transaction accepted at edge N (in_valid_i && in_ready_o) presents out_valid_o=1 after edge N+1.
- Throughput is one transaction per cycle when out_ready_i=1.
- When out_valid_o=1 && out_ready_i=0:
  - result_o, status_o and tag_o hold stable.
  - in_ready_o=0.
  - S1 holds its contents.
- Bubbles propagate; an empty S2 never blocks S1.
- busy_o = S1 valid || out_valid_o.
- A simultaneous flush_i and out_ready_i is resolved by flush: the result is dropped.
- Reset asserted mid-operation clears everything asynchronously. The first accept after rst_i falls behaves as from power-on.
- MAC sequence ordering is program order of acceptance.

## Test plan
- MUL with WIDTH=16, FRAC=8: a=0x0180+j0x0200 (1.5+j2), b=0x0080+j0xFF00 (0.5−j1), tag=1 → out_valid_o after edge N+1; result re=0x02C0, im=0xFF80; status=00; tag_o=1.
- CMUL with the same operands → re=0xFEC0 (−1.25), im=0x0280 (2.5).
- Rounding and saturation:
  - a=0x0001+j0, b=0x0080+j0 → re=0x0001.
  - a=0xFFFF+j0, b=0x0080+j0 → re=0x0000.
  - a=0x7F00+j0, b=0x0200+j0 → re=0x7FFF, status=01.
- MAC accumulation:
  - MAC_CLR followed back-to-back by MAC, both with the first test's operands → results 0x02C0/0xFF80, then 0x0580/0xFF00.
  - Then flush_i for one cycle, then MAC → 0x02C0/0xFF80 (acc cleared).
- Back-pressure: a stream of 4 MAC ops with out_ready_i held low 3 cycles mid-stream →
  - in_ready_o drops while S2 is full;
  - outputs stay stable;
  - no op is lost or accumulated twice;
  - final acc equals 4× the product.
- Reset mid-stream: rst_i pulsed while S1 and S2 are valid → out_valid_o=0 and busy_o=0 immediately; the next MAC returns the single product.
